// File: rtl/mfu_operand_packer.sv
// Operand packer for the multi-precision fused multiply unit: groups 1, 2 or 4
// signed element pairs into 8-bit lane-packed operand words with a ready/valid handshake.
module mfu_operand_packer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   input  logic [1:0]       in_mode,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_a,
   output logic [7:0]       out_b,
   output logic [1:0]       out_mode,
   output logic             err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic [1:0] {
      MODE_8X8  = 2'b00,
      MODE_4X4  = 2'b01,
      MODE_2X2  = 2'b10,
      MODE_NOOP = 2'b11
   } mode_e;

   logic [1:0] cnt;
   mode_e      grp_mode;
   logic [7:0] asm_a, asm_b;

   mode_e      eff_mode;
   logic [1:0] last_lane;
   logic [2:0] sh;
   logic [7:0] lane_a, lane_b;
   logic       range_bad, discard;
   logic       xfer_in, accept, closing;

   assign in_ready = !out_valid || out_ready;
   assign xfer_in  = in_valid && in_ready;
   assign accept   = xfer_in && !discard;
   assign closing  = accept && ((cnt == last_lane) || in_last);

   // The group mode is only sampled on its first element; later elements inherit it.
   assign eff_mode = (cnt == 2'd0) ? mode_e'(in_mode) : grp_mode;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      last_lane = 2'd0;
      sh        = 3'd0;
      lane_a    = 8'h00;
      lane_b    = 8'h00;
      range_bad = 1'b0;
      discard   = 1'b0;
      case (eff_mode)
         MODE_8X8: begin
            lane_a = in_a;
            lane_b = in_b;
         end
         MODE_4X4: begin
            last_lane = 2'd1;
            sh        = cnt[0] ? 3'd0 : 3'd4;
            lane_a    = {4'h0, in_a[3:0]} << sh;
            lane_b    = {4'h0, in_b[3:0]} << sh;
            range_bad = !((&in_a[7:3]) || !(|in_a[7:3])) ||
                        !((&in_b[7:3]) || !(|in_b[7:3]));
         end
         MODE_2X2: begin
            last_lane = 2'd3;
            sh        = 3'd6 - {cnt, 1'b0};
            lane_a    = {6'h00, in_a[1:0]} << sh;
            lane_b    = {6'h00, in_b[1:0]} << sh;
            range_bad = !((&in_a[7:1]) || !(|in_a[7:1])) ||
                        !((&in_b[7:1]) || !(|in_b[7:1]));
         end
         MODE_NOOP: discard = 1'b1;
      endcase
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt       <= 2'd0;
         grp_mode  <= MODE_8X8;
         asm_a     <= 8'h00;
         asm_b     <= 8'h00;
         out_valid <= 1'b0;
         out_a     <= 8'h00;
         out_b     <= 8'h00;
         out_mode  <= 2'b00;
         err       <= 1'b0;
         word_cnt  <= '0;
      end else begin
         if (accept) begin
            if (cnt == 2'd0)
               grp_mode <= eff_mode;
            if (closing) begin
               cnt      <= 2'd0;
               asm_a    <= 8'h00;
               asm_b    <= 8'h00;
               word_cnt <= word_cnt + CNT_W'(1);
            end else begin
               cnt   <= cnt + 2'd1;
               asm_a <= asm_a | lane_a;
               asm_b <= asm_b | lane_b;
            end
         end

         // A closing transfer can only happen when the output slot is free or draining.
         if (closing) begin
            out_valid <= 1'b1;
            out_a     <= asm_a | lane_a;
            out_b     <= asm_b | lane_b;
            out_mode  <= eff_mode;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         // A new violation wins over a simultaneous clear.
         if (accept && range_bad)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mfu_operand_packer.sv
// Directed self-checking bench for mfu_operand_packer: each task drives one
// scenario and compares outputs against hand-computed values.
module tb_mfu_operand_packer;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             nrst;
   logic             in_valid, in_ready;
   logic [7:0]       in_a, in_b;
   logic [1:0]       in_mode;
   logic             in_last;
   logic             out_valid, out_ready;
   logic [7:0]       out_a, out_b;
   logic [1:0]       out_mode;
   logic             err, err_clr;
   logic [CNT_W-1:0] word_cnt;

   int errors = 0;
   int checks = 0;

   mfu_operand_packer #(.CNT_W(CNT_W)) dut (
      .clk(clk), .nrst(nrst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_mode(out_mode),
      .err(err), .err_clr(err_clr), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   // One element transfer; callers guarantee in_ready is high at the edge.
   task automatic push(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] m, input logic l);
      in_a = a; in_b = b; in_mode = m; in_last = l; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      step(); step();
      nrst = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b exp 0", out_valid); end
      checks++; if (out_a !== 8'h00 || out_b !== 8'h00) begin errors++; $display("FAIL reset out_ab: got %h/%h exp 00/00", out_a, out_b); end
      checks++; if (out_mode !== 2'b00) begin errors++; $display("FAIL reset out_mode: got %b exp 00", out_mode); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b exp 0", err); end
      checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset word_cnt: got %0d exp 0", word_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b exp 1", in_ready); end
   endtask

   task automatic test_8x8();
      out_ready = 1'b1;
      push(8'h85, 8'h03, 2'b00, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_a !== 8'h85 || out_b !== 8'h03 || out_mode !== 2'b00)
         begin errors++; $display("FAIL 8x8 word: got v=%b %h/%h m=%b exp v=1 85/03 m=00", out_valid, out_a, out_b, out_mode); end
      checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL 8x8 word_cnt: got %0d exp 1", word_cnt); end
   endtask

   task automatic test_back_to_back();
      in_mode = 2'b00; in_last = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_a = 8'h10 + 8'(i); in_b = 8'hA0 + 8'(i); in_valid = 1'b1;
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1 || out_a !== 8'h10 + 8'(i) || out_b !== 8'hA0 + 8'(i))
            begin errors++; $display("FAIL b2b word %0d: got v=%b %h/%h exp v=1 %h/%h", i, out_valid, out_a, out_b, 8'h10 + 8'(i), 8'hA0 + 8'(i)); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b drain out_valid: got %b exp 0", out_valid); end
      checks++; if (word_cnt !== 16'd9) begin errors++; $display("FAIL b2b word_cnt: got %0d exp 9", word_cnt); end
   endtask

   task automatic test_4x4();
      push(8'h03, 8'hFE, 2'b01, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL 4x4 partial out_valid: got %b exp 0", out_valid); end
      push(8'hFF, 8'h05, 2'b01, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_a !== 8'h3F || out_b !== 8'hE5 || out_mode !== 2'b01)
         begin errors++; $display("FAIL 4x4 word: got v=%b %h/%h m=%b exp v=1 3f/e5 m=01", out_valid, out_a, out_b, out_mode); end
      checks++; if (err !== 1'b0 || word_cnt !== 16'd10) begin errors++; $display("FAIL 4x4 err/cnt: got %b/%0d exp 0/10", err, word_cnt); end
   endtask

   task automatic test_2x2();
      push(8'h01, 8'h01, 2'b10, 1'b0);
      push(8'hFF, 8'h01, 2'b10, 1'b0);
      push(8'hFE, 8'h01, 2'b10, 1'b0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL 2x2 partial out_valid: got %b exp 0", out_valid); end
      push(8'h00, 8'h01, 2'b10, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_a !== 8'h78 || out_b !== 8'h55 || out_mode !== 2'b10)
         begin errors++; $display("FAIL 2x2 word: got v=%b %h/%h m=%b exp v=1 78/55 m=10", out_valid, out_a, out_b, out_mode); end
      push(8'h01, 8'h01, 2'b10, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_a !== 8'h40 || out_b !== 8'h40 || out_mode !== 2'b10)
         begin errors++; $display("FAIL 2x2 early close: got v=%b %h/%h m=%b exp v=1 40/40 m=10", out_valid, out_a, out_b, out_mode); end
      checks++; if (word_cnt !== 16'd12) begin errors++; $display("FAIL 2x2 word_cnt: got %0d exp 12", word_cnt); end
   endtask

   task automatic test_mode_lock_noop();
      push(8'h01, 8'h03, 2'b01, 1'b0);
      push(8'h02, 8'h04, 2'b10, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_a !== 8'h12 || out_b !== 8'h34 || out_mode !== 2'b01)
         begin errors++; $display("FAIL mode lock: got v=%b %h/%h m=%b exp v=1 12/34 m=01", out_valid, out_a, out_b, out_mode); end
      push(8'h55, 8'h55, 2'b11, 1'b0);
      push(8'h66, 8'h66, 2'b11, 1'b1);
      checks++; if (out_valid !== 1'b0 || word_cnt !== 16'd13) begin errors++; $display("FAIL noop: got v=%b cnt=%0d exp v=0 cnt=13", out_valid, word_cnt); end
      push(8'h7A, 8'h11, 2'b00, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_a !== 8'h7A || out_b !== 8'h11 || out_mode !== 2'b00)
         begin errors++; $display("FAIL after noop: got v=%b %h/%h m=%b exp v=1 7a/11 m=00", out_valid, out_a, out_b, out_mode); end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      push(8'h11, 8'h22, 2'b00, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_a !== 8'h11 || in_ready !== 1'b0)
         begin errors++; $display("FAIL bp load: got v=%b a=%h rdy=%b exp v=1 a=11 rdy=0", out_valid, out_a, in_ready); end
      in_a = 8'h33; in_b = 8'h44; in_mode = 2'b00; in_valid = 1'b1;
      step(); step(); step();
      checks++; if (out_a !== 8'h11 || out_b !== 8'h22 || in_ready !== 1'b0 || word_cnt !== 16'd15)
         begin errors++; $display("FAIL bp hold: got %h/%h rdy=%b cnt=%0d exp 11/22 rdy=0 cnt=15", out_a, out_b, in_ready, word_cnt); end
      out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp release in_ready: got %b exp 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_a !== 8'h33 || out_b !== 8'h44 || word_cnt !== 16'd16)
         begin errors++; $display("FAIL bp next word: got v=%b %h/%h cnt=%0d exp v=1 33/44 cnt=16", out_valid, out_a, out_b, word_cnt); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp drain: got %b exp 0", out_valid); end
   endtask

   task automatic test_range_err();
      push(8'h08, 8'h01, 2'b01, 1'b0);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL range set: got %b exp 1", err); end
      push(8'h00, 8'h00, 2'b01, 1'b0);
      checks++; if (out_a !== 8'h80 || out_b !== 8'h10) begin errors++; $display("FAIL range pack: got %h/%h exp 80/10", out_a, out_b); end
      err_clr = 1'b1;
      step();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL range clear: got %b exp 0", err); end
      push(8'h10, 8'h00, 2'b01, 1'b1);
      err_clr = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL range set+clear: got %b exp 1", err); end
   endtask

   task automatic test_reset_mid_group();
      push(8'h01, 8'h01, 2'b10, 1'b0);
      push(8'hFF, 8'hFF, 2'b10, 1'b0);
      nrst = 1'b0;
      step();
      nrst = 1'b1;
      checks++; if (out_valid !== 1'b0 || out_a !== 8'h00 || out_b !== 8'h00 || out_mode !== 2'b00 || err !== 1'b0 || word_cnt !== 16'd0)
         begin errors++; $display("FAIL mid reset: got v=%b %h/%h m=%b e=%b cnt=%0d exp all 0", out_valid, out_a, out_b, out_mode, err, word_cnt); end
      push(8'h00, 8'h01, 2'b10, 1'b0);
      push(8'h00, 8'h00, 2'b10, 1'b0);
      push(8'h00, 8'h00, 2'b10, 1'b0);
      push(8'h01, 8'h00, 2'b10, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_a !== 8'h01 || out_b !== 8'h40 || out_mode !== 2'b10 || word_cnt !== 16'd1)
         begin errors++; $display("FAIL fresh group: got v=%b %h/%h m=%b cnt=%0d exp v=1 01/40 m=10 cnt=1", out_valid, out_a, out_b, out_mode, word_cnt); end
   endtask

   initial begin
      nrst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 2'b00;
      in_last = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
      test_reset();
      test_8x8();
      test_back_to_back();
      test_4x4();
      test_2x2();
      test_mode_lock_noop();
      test_backpressure();
      test_range_err();
      test_reset_mid_group();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
